// File: rtl/alu_pkg.sv
// Shared opcode encoding and NZCV flag bit positions for the ARM ALU.
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_ORR = 2'b11
    } alu_op_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_adder.sv
// N-bit ripple-style adder with carry-in and carry-out.
// ADD and SUB share this single adder.
module alu_adder #(
    parameter int N = 32
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);

    logic [N:0] total;

    assign total  = {1'b0, a_i} + {1'b0, b_i} + {{N{1'b0}}, cin_i};
    assign sum_o  = total[N-1:0];
    assign cout_o = total[N];

endmodule

// File: rtl/arm_alu.sv
// Registered N-bit ALU (ADD/SUB/AND/ORR) producing NZCV flags one cycle after capture.
// Optional sticky overflow flag when ALU_STICKY_OVF_EN is defined.
module arm_alu
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         valid_i,
    input  logic [1:0]   opcode_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
`ifdef ALU_STICKY_OVF_EN
    input  logic         ovf_clr_i,
    output logic         ovf_sticky_o,
`endif
    output logic [N-1:0] result_o,
    output logic [3:0]   ALUFlags,
    output logic         valid_o
);

    alu_op_e      op;
    logic [N-1:0] b_eff;
    logic         cin;
    logic [N-1:0] sum;
    logic         cout;
    logic [N-1:0] result_d, result_q;
    logic [3:0]   flags_d, flags_q;
    logic         valid_q;
    logic         carry, ovf;

    assign op    = alu_op_e'(opcode_i);
    // SUB is a + ~b + 1 through the same adder
    assign b_eff = (op == ALU_SUB) ? ~b_i : b_i;
    assign cin   = (op == ALU_SUB);

    alu_adder #(.N(N)) u_adder (
        .a_i    (a_i),
        .b_i    (b_eff),
        .cin_i  (cin),
        .sum_o  (sum),
        .cout_o (cout)
    );

    always_comb begin
        result_d = '0;
        carry    = 1'b0;
        ovf      = 1'b0;
        case (op)
            ALU_ADD, ALU_SUB: begin
                result_d = sum;
                carry    = cout;
                ovf      = (a_i[N-1] == b_eff[N-1]) && (sum[N-1] != a_i[N-1]);
            end
            ALU_AND: result_d = a_i & b_i;
            ALU_ORR: result_d = a_i | b_i;
            default: result_d = '0;
        endcase
    end

    always_comb begin
        flags_d         = 4'b0000;
        flags_d[FLAG_N] = result_d[N-1];
        flags_d[FLAG_Z] = (result_d == '0);
        flags_d[FLAG_C] = carry;
        flags_d[FLAG_V] = ovf;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            result_q <= '0;
            flags_q  <= 4'b0000;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) begin
                result_q <= result_d;
                flags_q  <= flags_d;
            end
        end
    end

    assign result_o = result_q;
    assign ALUFlags = flags_q;
    assign valid_o  = valid_q;

`ifdef ALU_STICKY_OVF_EN
    logic sticky_d, sticky_q;

    // a new overflow takes priority over a simultaneous clear
    always_comb begin
        sticky_d = sticky_q;
        if (ovf_clr_i)
            sticky_d = 1'b0;
        if (valid_i && ovf)
            sticky_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            sticky_q <= 1'b0;
        else
            sticky_q <= sticky_d;
    end

    assign ovf_sticky_o = sticky_q;
`endif

endmodule

// File: tb/tb_arm_alu.sv
// Directed self-checking bench for arm_alu (N=32); sticky-overflow checks when ALU_STICKY_OVF_EN is defined.
module tb_arm_alu;

    localparam int N = 32;

    logic         clk;
    logic         rst_n;
    logic         valid_i;
    logic [1:0]   opcode_i;
    logic [N-1:0] a_i, b_i;
    logic [N-1:0] result_o;
    logic [3:0]   flags_o;
    logic         valid_o;
`ifdef ALU_STICKY_OVF_EN
    logic         ovf_clr_i;
    logic         ovf_sticky_o;
`endif

    int n_cmp = 0;
    int n_err = 0;

    arm_alu #(.N(N)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .valid_i      (valid_i),
        .opcode_i     (opcode_i),
        .a_i          (a_i),
        .b_i          (b_i),
`ifdef ALU_STICKY_OVF_EN
        .ovf_clr_i    (ovf_clr_i),
        .ovf_sticky_o (ovf_sticky_o),
`endif
        .result_o     (result_o),
        .ALUFlags     (flags_o),
        .valid_o      (valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one operation for a single edge, then sample 1 time unit after it.
    task automatic drive_op(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        opcode_i = op;
        a_i      = a;
        b_i      = b;
        valid_i  = 1'b1;
        @(posedge clk);
        #1;
        valid_i  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_cmp++;
        if (result_o !== '0 || flags_o !== 4'b0000 || valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset: result=%h flags=%b valid=%b, want 0/0000/0", result_o, flags_o, valid_o);
        end
    endtask

    task automatic test_arith();
        logic [1:0]   op_t  [6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b00};
        logic [N-1:0] a_t   [6] = '{32'd1, 32'd10, 32'd10, 32'd10, 32'd1, 32'h7FFF_FFFF};
        logic [N-1:0] b_t   [6] = '{32'd10, 32'd10, 32'd10, 32'd10, 32'd10, 32'd1};
        logic [N-1:0] r_t   [6] = '{32'd11, 32'd0, 32'd10, 32'd10, 32'hFFFF_FFF7, 32'h8000_0000};
        logic [3:0]   f_t   [6] = '{4'b0000, 4'b0110, 4'b0000, 4'b0000, 4'b1000, 4'b1001};
        for (int i = 0; i < 6; i++) begin
            drive_op(op_t[i], a_t[i], b_t[i]);
            n_cmp++;
            if (result_o !== r_t[i] || flags_o !== f_t[i] || valid_o !== 1'b1) begin
                n_err++;
                $display("FAIL arith[%0d]: result=%h flags=%b valid=%b, want %h/%b/1",
                         i, result_o, flags_o, valid_o, r_t[i], f_t[i]);
            end
        end
    endtask

    task automatic test_hold();
        drive_op(2'b00, 32'hFFFF_FFFF, 32'd1);
        n_cmp++;
        if (result_o !== 32'd0 || flags_o !== 4'b0110) begin
            n_err++;
            $display("FAIL add_wrap: result=%h flags=%b, want 00000000/0110", result_o, flags_o);
        end
        // operands change while idle; outputs must not follow
        a_i = 32'h1234_5678;
        b_i = 32'h0000_0001;
        opcode_i = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (result_o !== 32'd0 || flags_o !== 4'b0110 || valid_o !== 1'b0) begin
                n_err++;
                $display("FAIL hold[%0d]: result=%h flags=%b valid=%b, want 00000000/0110/0",
                         i, result_o, flags_o, valid_o);
            end
        end
    endtask

    task automatic test_back_to_back();
        opcode_i = 2'b01; a_i = 32'd5;           b_i = 32'd3;  valid_i = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (result_o !== 32'd2 || flags_o !== 4'b0010 || valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL b2b[0]: result=%h flags=%b valid=%b, want 00000002/0010/1", result_o, flags_o, valid_o);
        end
        opcode_i = 2'b01; a_i = 32'h8000_0000;   b_i = 32'd1;
        @(posedge clk); #1;
        n_cmp++;
        if (result_o !== 32'h7FFF_FFFF || flags_o !== 4'b0011 || valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL b2b[1]: result=%h flags=%b valid=%b, want 7fffffff/0011/1", result_o, flags_o, valid_o);
        end
        opcode_i = 2'b10; a_i = 32'hF0F0_0000;   b_i = 32'hFF00_00FF;
        @(posedge clk); #1;
        valid_i = 1'b0;
        n_cmp++;
        if (result_o !== 32'hF000_0000 || flags_o !== 4'b1000 || valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL b2b[2]: result=%h flags=%b valid=%b, want f0000000/1000/1", result_o, flags_o, valid_o);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (valid_o !== 1'b0 || result_o !== 32'hF000_0000) begin
            n_err++;
            $display("FAIL b2b_idle: result=%h valid=%b, want f0000000/0", result_o, valid_o);
        end
    endtask

    task automatic test_async_reset();
        drive_op(2'b11, 32'h0000_00F0, 32'h0000_000F);
        n_cmp++;
        if (result_o !== 32'h0000_00FF || flags_o !== 4'b0000) begin
            n_err++;
            $display("FAIL orr: result=%h flags=%b, want 000000ff/0000", result_o, flags_o);
        end
        opcode_i = 2'b00; a_i = 32'd7; b_i = 32'd9; valid_i = 1'b1;
        @(posedge clk); #2;
        // mid-cycle: no clock edge between here and the check
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (result_o !== '0 || flags_o !== 4'b0000 || valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: result=%h flags=%b valid=%b, want 0/0000/0", result_o, flags_o, valid_o);
        end
        valid_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

`ifdef ALU_STICKY_OVF_EN
    task automatic test_sticky();
        n_cmp++;
        if (ovf_sticky_o !== 1'b0) begin
            n_err++;
            $display("FAIL sticky_rst: sticky=%b, want 0", ovf_sticky_o);
        end
        drive_op(2'b00, 32'h7FFF_FFFF, 32'd1);
        n_cmp++;
        if (ovf_sticky_o !== 1'b1) begin
            n_err++;
            $display("FAIL sticky_set: sticky=%b, want 1", ovf_sticky_o);
        end
        drive_op(2'b00, 32'd1, 32'd2);
        n_cmp++;
        if (ovf_sticky_o !== 1'b1 || flags_o[0] !== 1'b0) begin
            n_err++;
            $display("FAIL sticky_persist: sticky=%b V=%b, want 1/0", ovf_sticky_o, flags_o[0]);
        end
        ovf_clr_i = 1'b1;
        @(posedge clk); #1;
        ovf_clr_i = 1'b0;
        n_cmp++;
        if (ovf_sticky_o !== 1'b0) begin
            n_err++;
            $display("FAIL sticky_clr: sticky=%b, want 0", ovf_sticky_o);
        end
        ovf_clr_i = 1'b1;
        drive_op(2'b01, 32'h8000_0000, 32'd1);
        ovf_clr_i = 1'b0;
        n_cmp++;
        if (ovf_sticky_o !== 1'b1) begin
            n_err++;
            $display("FAIL sticky_set_wins: sticky=%b, want 1", ovf_sticky_o);
        end
    endtask
`endif

    initial begin
        rst_n    = 1'b0;
        valid_i  = 1'b0;
        opcode_i = 2'b00;
        a_i      = '0;
        b_i      = '0;
`ifdef ALU_STICKY_OVF_EN
        ovf_clr_i = 1'b0;
`endif
        #2;
        test_reset();
        test_arith();
        test_hold();
        test_back_to_back();
        test_async_reset();
`ifdef ALU_STICKY_OVF_EN
        test_sticky();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
